// File: rtl/inv_cipher.sv
// inv_cipher: iterative AES-128 inverse cipher, one round per clock from a shared key RAM.
// Define INV_CIPHER_KEY_LAT0_EN when the key RAM is combinational (no PRIME cycle).
module inv_cipher (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic [127:0] ciphertext,
   input  logic [127:0] key,
   output logic [127:0] plaintext,
   output logic [3:0]   round_key_no,
   output logic         en_o,
   output logic         busy
);
   localparam logic [3:0] NR = 4'd10;
   typedef enum logic [1:0] {IDLE, PRIME, ROUND} fsm_t;
   fsm_t fsm, fsm_nxt;
   logic [127:0] st, st_nxt, pt_nxt, ark, mc;
   logic [3:0]   rnd, rnd_nxt, rkn_nxt;
   logic         en_o_nxt, busy_nxt;
   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction
   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         p = b[i] ? p ^ x : p;
         x = xt(x);
      end
      return p;
   endfunction
   // inverse affine map, then GF(2^8) inverse as x^254 by repeated squaring
   function automatic logic [7:0] inv_sbox(input logic [7:0] y);
      logic [7:0] t, r;
      t = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
      r = 8'h01;
      for (int i = 1; i < 8; i++) begin
         t = gm(t, t);
         r = gm(r, t);
      end
      return r;
   endfunction
   // byte n sits at [127-8n -: 8]; row = n%4, column = n/4
   function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
      logic [127:0] o;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(4*c+r) -: 8] = inv_sbox(s[127-8*(4*((c-r+4)%4)+r) -: 8]);
      return o;
   endfunction
   function automatic logic [127:0] inv_mix_cols(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         {a0, a1, a2, a3} = s[127-32*c -: 32];
         o[127-32*c -: 32] = {gm(a0, 8'h0e) ^ gm(a1, 8'h0b) ^ gm(a2, 8'h0d) ^ gm(a3, 8'h09),
                              gm(a0, 8'h09) ^ gm(a1, 8'h0e) ^ gm(a2, 8'h0b) ^ gm(a3, 8'h0d),
                              gm(a0, 8'h0d) ^ gm(a1, 8'h09) ^ gm(a2, 8'h0e) ^ gm(a3, 8'h0b),
                              gm(a0, 8'h0b) ^ gm(a1, 8'h0d) ^ gm(a2, 8'h09) ^ gm(a3, 8'h0e)};
      end
      return o;
   endfunction
   assign ark = inv_shift_sub(st) ^ key;
   assign mc  = inv_mix_cols(ark);
   always_ff @(posedge clk)
      fsm <= reset ? IDLE : fsm_nxt;
   always_comb begin
`ifdef INV_CIPHER_KEY_LAT0_EN
      fsm_nxt = (fsm == IDLE)  ? (en ? ROUND : IDLE) :
                (fsm == ROUND && rnd == 4'd0) ? IDLE : fsm;
`else
      fsm_nxt = (fsm == IDLE)  ? (en ? PRIME : IDLE) :
                (fsm == PRIME) ? ROUND :
                (fsm == ROUND && rnd == 4'd0) ? IDLE : fsm;
`endif
   end
   always_comb begin
      st_nxt   = st;
      pt_nxt   = plaintext;
      rnd_nxt  = rnd;
      rkn_nxt  = round_key_no;
      en_o_nxt = 1'b0;
      busy_nxt = busy;
      case (fsm)
         IDLE: if (en) begin
            st_nxt   = ciphertext;
            rkn_nxt  = NR;
            busy_nxt = 1'b1;
`ifdef INV_CIPHER_KEY_LAT0_EN
            rnd_nxt  = NR;
`endif
         end
         PRIME: begin
            rkn_nxt = NR - 4'd1;
            rnd_nxt = NR;
         end
         ROUND: begin
            rnd_nxt  = (rnd == 4'd0) ? 4'd0 : rnd - 4'd1;
            rkn_nxt  = (round_key_no == 4'd0) ? 4'd0 : round_key_no - 4'd1;
            st_nxt   = (rnd == NR) ? st ^ key : mc;
            pt_nxt   = (rnd == 4'd0) ? ark : plaintext;
            en_o_nxt = (rnd == 4'd0);
            busy_nxt = (rnd != 4'd0);
         end
         default: ;
      endcase
   end
   always_ff @(posedge clk)
      if (reset) begin
         st           <= '0;
         plaintext    <= '0;
         rnd          <= '0;
         round_key_no <= '0;
         en_o         <= 1'b0;
         busy         <= 1'b0;
      end else begin
         st           <= st_nxt;
         plaintext    <= pt_nxt;
         rnd          <= rnd_nxt;
         round_key_no <= rkn_nxt;
         en_o         <= en_o_nxt;
         busy         <= busy_nxt;
      end
endmodule
